// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one AHB-style single-beat master port between the IF and MEM requesters.
// Define ARB_FAIRNESS_EN to add the IF starvation guard (STARVE_MAX consecutive MEM grants).
module mem_bus_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [2:0]        mem_size,
    output logic              mem_ack,
    output logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] HADDR,
    output logic [DATA_W-1:0] HWDATA,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic              HTRANS,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY
);

    // state  | meaning
    // S_IDLE | no transfer; arbitrate pending requests
    // S_ADDR | address phase on the bus (HTRANS=1 this cycle)
    // S_DATA | data phase; wait for HREADY, then ack the owner
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    localparam logic [2:0] IF_HSIZE = 3'd2;

    if (STARVE_MAX < 1) begin : g_cfg_check
        $error("mem_bus_arbiter: STARVE_MAX must be at least 1");
    end

    state_t            r_state;
    logic              r_owner_if;
    logic              r_flushed;
    logic [DATA_W-1:0] r_wdata;

    logic w_if_pend;
    logic w_mem_pend;
    logic w_starved;
    logic w_grant;
    logic w_grant_if;
    logic w_if_flush_own;

    // The ack cycle is a no-grant cycle: the acked requester still shows its
    // request this cycle and must not be served twice.
    assign w_if_pend      = if_req & ~if_flush;
    assign w_mem_pend     = mem_req;
    assign w_grant        = (w_if_pend | w_mem_pend) & ~(if_ack | mem_ack);
    assign w_grant_if     = w_if_pend & (~w_mem_pend | w_starved);
    assign w_if_flush_own = r_owner_if & if_flush;

`ifdef ARB_FAIRNESS_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] r_starve;

    assign w_starved = (r_starve == CNT_MAX);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_starve <= '0;
        end else if (r_state == S_IDLE) begin
            if (!if_req) begin
                r_starve <= '0;
            end else if (w_grant) begin
                if (w_grant_if) begin
                    r_starve <= '0;
                end else if (!w_starved) begin
                    r_starve <= r_starve + CNT_W'(1);
                end
            end
        end
    end
`else
    assign w_starved = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state    <= S_IDLE;
            r_owner_if <= 1'b0;
            r_flushed  <= 1'b0;
            r_wdata    <= '0;
            HADDR      <= '0;
            HWDATA     <= '0;
            HWRITE     <= 1'b0;
            HSIZE      <= '0;
            HTRANS     <= 1'b0;
            if_ack     <= 1'b0;
            if_rdata   <= '0;
            mem_ack    <= 1'b0;
            mem_rdata  <= '0;
        end else begin
            if_ack  <= 1'b0;
            mem_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_state   <= S_ADDR;
                        HTRANS    <= 1'b1;
                        r_flushed <= 1'b0;
                        if (w_grant_if) begin
                            r_owner_if <= 1'b1;
                            HADDR      <= if_addr;
                            HWRITE     <= 1'b0;
                            HSIZE      <= IF_HSIZE;
                            r_wdata    <= '0;
                        end else begin
                            r_owner_if <= 1'b0;
                            HADDR      <= mem_addr;
                            HWRITE     <= mem_write;
                            HSIZE      <= mem_size;
                            r_wdata    <= mem_wdata;
                        end
                    end
                end
                S_ADDR: begin
                    r_state <= S_DATA;
                    HTRANS  <= 1'b0;
                    HWDATA  <= HWRITE ? r_wdata : '0;
                    if (w_if_flush_own) begin
                        r_flushed <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_if_flush_own) begin
                        r_flushed <= 1'b1;
                    end
                    if (HREADY) begin
                        r_state <= S_IDLE;
                        if (r_owner_if) begin
                            // a flushed fetch still finishes on the bus but is dropped here
                            if (!(r_flushed | if_flush)) begin
                                if_rdata <= HRDATA;
                                if_ack   <= 1'b1;
                            end
                        end else begin
                            mem_ack <= 1'b1;
                            if (!HWRITE) begin
                                mem_rdata <= HRDATA;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    HTRANS  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: vector table, directed corner sequences and a random run
// against a transaction-level model (ARB_FAIRNESS_EN selects the expected grant policy).
module tb_mem_bus_arbiter;

    localparam int AW   = 64;
    localparam int DW   = 64;
    localparam int SMAX = 4;
`ifdef ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RSTN = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_flush = 1'b0;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          mem_req = 1'b0;
    logic          mem_write = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_wdata = '0;
    logic [2:0]    mem_size = '0;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] HADDR;
    logic [DW-1:0] HWDATA;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic          HTRANS;
    logic [DW-1:0] HRDATA = '0;
    logic          HREADY = 1'b0;

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_ack(if_ack), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_size(mem_size),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HTRANS(HTRANS), .HRDATA(HRDATA), .HREADY(HREADY)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_if_rd  = '0;
    logic [63:0] exp_mem_rd = '0;

    typedef struct {
        bit          is_if;
        bit          wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [2:0]  size;
        logic [63:0] rdata;
        int          waits;
        int          exp_lat;
        logic [2:0]  exp_size;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int    got;
        string t;
        t   = $sformatf("vec%0d", idx);
        got = -1;
        HRDATA = v.rdata;
        HREADY = 1'b0;
        if (v.is_if) begin
            if_req  = 1'b1;
            if_addr = v.addr;
        end else begin
            mem_req   = 1'b1;
            mem_write = v.wr;
            mem_addr  = v.addr;
            mem_wdata = v.wdata;
            mem_size  = v.size;
        end
        for (int k = 1; k <= 20 && got < 0; k++) begin
            step();
            chk({t, "_htrans"}, HTRANS, (k == 1) ? 1'b1 : 1'b0);
            chk({t, "_haddr"}, HADDR, v.addr);
            if (k == 1) begin
                chk({t, "_hwrite"}, HWRITE, v.wr);
                chk({t, "_hsize"}, HSIZE, v.exp_size);
            end
            if (k == 2 && v.wr) chk({t, "_hwdata"}, HWDATA, v.wdata);
            if ((v.is_if ? if_ack : mem_ack) === 1'b1) got = k;
            HREADY = (k + 1 >= 3 + v.waits);
        end
        chk({t, "_latency"}, got, v.exp_lat);
        if_req  = 1'b0;
        mem_req = 1'b0;
        HREADY  = 1'b0;
        if (!v.wr) begin
            if (v.is_if) exp_if_rd = v.rdata;
            else         exp_mem_rd = v.rdata;
        end
        chk({t, "_if_rdata"}, if_rdata, exp_if_rd);
        chk({t, "_mem_rdata"}, mem_rdata, exp_mem_rd);
        step();
        chk({t, "_ack_pulse"}, {if_ack, mem_ack}, 2'b00);
    endtask

    task automatic run_random(input int ncyc);
        int          own;   // 0 none, 1 IF, 2 MEM
        int          age;
        int          streak;
        bit          ack_last;
        bit          e_htrans, e_ifack, e_memack, granted, done, pick_if;
        logic [63:0] l_addr, l_wdata;
        bit          l_wr;
        logic [2:0]  l_size;
        own = 0; age = 0; streak = 0; ack_last = 1'b0;
        l_addr = '0; l_wdata = '0; l_wr = 1'b0; l_size = '0;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            e_htrans = 0; e_ifack = 0; e_memack = 0; granted = 0; done = 0; pick_if = 0;
            if (!mem_req && $urandom_range(0, 2) == 0) begin
                mem_req   = 1'b1;
                mem_write = 1'($urandom_range(0, 1));
                mem_addr  = {$urandom, $urandom};
                mem_wdata = {$urandom, $urandom};
                mem_size  = 3'($urandom_range(0, 3));
            end
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req  = 1'b1;
                if_addr = {$urandom, $urandom};
            end
            HREADY = ($urandom_range(0, 3) != 0);
            HRDATA = {$urandom, $urandom};
            if (own == 0) begin
                if (!ack_last && (if_req || mem_req)) begin
                    granted = 1;
                    pick_if = if_req && (!mem_req || (FAIR && streak >= SMAX));
                    e_htrans = 1;
                    age = 0;
                    if (pick_if) begin
                        own = 1; l_addr = if_addr; l_wr = 0; l_size = 3'd2; l_wdata = '0;
                    end else begin
                        own = 2; l_addr = mem_addr; l_wr = mem_write; l_size = mem_size; l_wdata = mem_wdata;
                    end
                end
                if (!if_req) streak = 0;
                else if (granted) streak = pick_if ? 0 : ((streak + 1 > SMAX) ? SMAX : streak + 1);
            end else begin
                age++;
                if (age >= 2 && HREADY) begin
                    done = 1;
                    if (own == 1) begin
                        e_ifack = 1; exp_if_rd = HRDATA;
                    end else begin
                        e_memack = 1;
                        if (!l_wr) exp_mem_rd = HRDATA;
                    end
                end
            end
            step();
            chk("rnd_htrans", HTRANS, e_htrans);
            chk("rnd_if_ack", if_ack, e_ifack);
            chk("rnd_mem_ack", mem_ack, e_memack);
            chk("rnd_if_rdata", if_rdata, exp_if_rd);
            chk("rnd_mem_rdata", mem_rdata, exp_mem_rd);
            if (own != 0) begin
                chk("rnd_haddr", HADDR, l_addr);
                chk("rnd_hwrite", HWRITE, l_wr);
                chk("rnd_hsize", HSIZE, l_size);
                if (age == 1 && l_wr) chk("rnd_hwdata", HWDATA, l_wdata);
            end
            ack_last = e_ifack | e_memack;
            if (done) begin
                if (own == 1) if_req = 1'b0;
                else          mem_req = 1'b0;
                own = 0;
            end
            if (granted) begin
                if (own == 1) begin
                    if_addr = {$urandom, $urandom};
                end else begin
                    mem_addr  = {$urandom, $urandom};
                    mem_wdata = {$urandom, $urandom};
                    mem_write = 1'($urandom_range(0, 1));
                    mem_size  = 3'($urandom_range(0, 3));
                end
            end
        end
        if_req  = 1'b0;
        mem_req = 1'b0;
    endtask

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          got;
        int          grants;
        bit          exp_own[6];
        logic [63:0] own_addr;

        //            is_if wr  addr        wdata    size  rdata                  waits lat size_exp
        vecs[0] = '{1'b1, 1'b0, 64'h1000, 64'h0,    3'd0, 64'h13,                0, 3, 3'd2};
        vecs[1] = '{1'b0, 1'b1, 64'h2000, 64'hAB,   3'd3, 64'hDEAD,              0, 3, 3'd3};
        vecs[2] = '{1'b0, 1'b0, 64'h3000, 64'h0,    3'd2, 64'h1122334455667788,  4, 7, 3'd2};
        vecs[3] = '{1'b1, 1'b0, 64'h1008, 64'h0,    3'd0, 64'hCAFEF00D,          2, 5, 3'd2};
        vecs[4] = '{1'b0, 1'b0, 64'h3001, 64'h0,    3'd0, 64'hFF,                1, 4, 3'd0};
        vecs[5] = '{1'b0, 1'b1, 64'h3002, 64'hBEEF, 3'd1, 64'h5555,              3, 6, 3'd1};

        // reset state
        step();
        step();
        chk("rst_htrans", HTRANS, 1'b0);
        chk("rst_haddr", HADDR, 64'h0);
        chk("rst_acks", {if_ack, mem_ack}, 2'b00);
        chk("rst_rdata", if_rdata | mem_rdata, 64'h0);
        chk("rst_hwrite_hsize", {HWRITE, HSIZE}, 4'h0);
        RSTN = 1'b1;
        step();

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // collision: MEM store wins, IF follows after the ack cycle
        HRDATA = 64'h99; HREADY = 1'b1;
        if_req = 1'b1; if_addr = 64'h1000;
        mem_req = 1'b1; mem_write = 1'b1; mem_addr = 64'h2000; mem_wdata = 64'hAB; mem_size = 3'd3;
        step();
        chk("col_haddr_mem", HADDR, 64'h2000);
        chk("col_hwrite_mem", HWRITE, 1'b1);
        step();
        chk("col_hwdata", HWDATA, 64'hAB);
        step();
        chk("col_acks_mem", {if_ack, mem_ack}, 2'b01);
        mem_req = 1'b0;
        step();
        chk("col_gap", {HTRANS, mem_ack}, 2'b00);
        step();
        chk("col_htrans_if", HTRANS, 1'b1);
        chk("col_haddr_if", HADDR, 64'h1000);
        chk("col_hwrite_hsize_if", {HWRITE, HSIZE}, 4'b0010);
        step();
        step();
        chk("col_acks_if", {if_ack, mem_ack}, 2'b10);
        exp_if_rd = 64'h99;
        chk("col_if_rdata", if_rdata, exp_if_rd);
        chk("col_mem_rdata_store", mem_rdata, exp_mem_rd);
        if_req = 1'b0;
        step();

        // flush: blocked while idle, then suppressed ack in DATA
        HREADY = 1'b0; HRDATA = 64'h66;
        if_req = 1'b1; if_addr = 64'h4000; if_flush = 1'b1;
        step();
        chk("flush_idle_nogrant", HTRANS, 1'b0);
        if_flush = 1'b0;
        step();
        chk("flush_grant", {HTRANS, HADDR}, {1'b1, 64'h4000});
        step();
        if_flush = 1'b1;
        step();
        if_flush = 1'b0; if_req = 1'b0; HREADY = 1'b1;
        step();
        chk("flush_no_ack", if_ack, 1'b0);
        chk("flush_rdata_held", if_rdata, exp_if_rd);
        HRDATA = 64'h77;
        mem_req = 1'b1; mem_write = 1'b0; mem_addr = 64'h5000; mem_size = 3'd3;
        step();
        chk("flush_next_grant", {HTRANS, HADDR}, {1'b1, 64'h5000});
        got = -1;
        for (int k = 2; k <= 12 && got < 0; k++) begin
            step();
            if (if_ack) chk("flush_stray_if_ack", if_ack, 1'b0);
            if (mem_ack) got = k;
        end
        chk("flush_mem_latency", got, 3);
        exp_mem_rd = 64'h77;
        chk("flush_mem_rdata", mem_rdata, exp_mem_rd);
        mem_req = 1'b0;
        step();

        // request dropped right after grant still completes
        HRDATA = 64'h4242; HREADY = 1'b1;
        mem_req = 1'b1; mem_write = 1'b0; mem_addr = 64'h7000; mem_size = 3'd2;
        step();
        chk("drop_grant", HTRANS, 1'b1);
        mem_req = 1'b0; mem_addr = 64'hFFFF;
        step();
        chk("drop_haddr_latched", HADDR, 64'h7000);
        step();
        chk("drop_ack", mem_ack, 1'b1);
        exp_mem_rd = 64'h4242;
        chk("drop_rdata", mem_rdata, exp_mem_rd);
        step();

        // both held high: grant order
        for (int i = 0; i < 6; i++) exp_own[i] = FAIR && (i == 4);
        HRDATA = 64'h31; HREADY = 1'b1;
        if_req = 1'b1; if_addr = 64'hA000;
        mem_req = 1'b1; mem_write = 1'b0; mem_addr = 64'hB000; mem_size = 3'd3;
        grants = 0;
        for (int c = 0; c < 60 && grants < 6; c++) begin
            step();
            if (HTRANS) begin
                own_addr = exp_own[grants] ? 64'hA000 : 64'hB000;
                chk($sformatf("order%0d", grants), HADDR, own_addr);
                grants++;
            end
        end
        chk("order_count", grants, 6);
        if_req = 1'b0; mem_req = 1'b0;
        repeat (6) step();
        exp_mem_rd = 64'h31;
        if (FAIR) exp_if_rd = 64'h31;
        chk("order_mem_rdata", mem_rdata, exp_mem_rd);
        chk("order_if_rdata", if_rdata, exp_if_rd);

        // asynchronous reset during DATA
        HREADY = 1'b0;
        mem_req = 1'b1; mem_write = 1'b0; mem_addr = 64'h6000; mem_size = 3'd3;
        step();
        step();
        chk("arst_pre_haddr", HADDR, 64'h6000);
        #2 RSTN = 1'b0;
        #1;
        chk("arst_haddr", HADDR, 64'h0);
        chk("arst_htrans_acks", {HTRANS, if_ack, mem_ack}, 3'b000);
        chk("arst_rdata", if_rdata | mem_rdata, 64'h0);
        mem_req = 1'b0;
        step();
        RSTN = 1'b1;
        exp_if_rd = '0; exp_mem_rd = '0;
        step();
        chk("arst_idle", HTRANS, 1'b0);
        run_vec(vecs[0], 6);

        run_random(3000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
